// File: rtl/addsub_serial_ctrl_if.sv
// rtl/addsub_serial_ctrl_if.sv - request/result handshake bundle for the nibble-serial add/sub unit
interface addsub_serial_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, res, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, res, cout, ovf, busy
  );
endinterface

// File: rtl/addsub_serial_ctrl.sv
// rtl/addsub_serial_ctrl.sv - nibble-serial adder/subtractor reusing one 4-bit add/sub slice
module adder_sub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ctr,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] total;

  assign total = {1'b0, a} + {1'b0, b ^ {4{ctr}}} + {4'b0000, cin};
  assign sum   = total[3:0];
  assign cout  = total[4];
endmodule

module addsub_serial_ctrl #(
  parameter int NIB = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_serial_ctrl_if.slave  bus
);
  localparam int W  = 4 * NIB;
  localparam int CW = $clog2(NIB);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_q, b_q, res_q;
  logic           sub_q, carry_q, cout_q, ovf_q;
  logic [CW-1:0]  cnt;
  logic [3:0]     a_nib, b_nib, sum_nib;
  logic           slice_cout;
  logic           accept, last;
  logic           in_ready_c, out_valid_c, busy_c;

  assign a_nib = a_q[{cnt, 2'b00} +: 4];
  assign b_nib = b_q[{cnt, 2'b00} +: 4];
  assign last  = (cnt == CW'(NIB - 1));

  adder_sub_4bit u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .ctr  (sub_q),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        accept     = bus.in_valid;
        if (bus.in_valid) state_nx = RUN;
      end
      RUN: begin
        busy_c = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Carry register is seeded with op_sub so nibble 0 completes the a + ~b + 1 subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            sub_q   <= bus.op_sub;
            carry_q <= bus.op_sub;
            cnt     <= '0;
          end
        end
        RUN: begin
          res_q[{cnt, 2'b00} +: 4] <= sum_nib;
          carry_q                  <= slice_cout;
          cnt                      <= cnt + 1'b1;
          if (last) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_q[W-1] == (b_q[W-1] ^ sub_q)) & (sum_nib[3] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.res       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// tb/tb_addsub_serial_ctrl.sv - scoreboard bench for the nibble-serial add/sub unit
module tb_addsub_serial_ctrl;
  localparam int NIB = 4;
  localparam int W   = 16;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  addsub_serial_ctrl_if #(.W(W)) bus ();

  addsub_serial_ctrl #(.NIB(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t         e;
    logic [W:0]   full;
    logic [W-1:0] beff;
    beff   = b ^ {W{sub}};
    full   = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, sub};
    e.res  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input bit scramble, input bit keep_ready, output int lat,
                       output logic [W-1:0] r, output logic c, output logic o);
    int wait_n;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    bus.out_ready = keep_ready;
    wait_n = 0;
    while (!bus.in_ready && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(a, b, sub));
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      if (scramble) begin
        bus.op_a   = W'($urandom);
        bus.op_b   = W'($urandom);
        bus.op_sub = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    r = bus.res;
    c = bus.cout;
    o = bus.ovf;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = keep_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0; bus.out_ready = 1'b0;
    #2;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.res !== 16'h0000) begin n_fail++; $display("FAIL reset_res: got %h expected 0000", bus.res); end
    n_checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b expected 00", {bus.cout, bus.ovf}); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; logic [W-1:0] r; logic c, o; exp_t e;
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, lat, r, c, o);
    e = sb.pop_front();
    n_checks++; if (lat !== NIB) begin n_fail++; $display("FAIL add_latency: got %0d expected %0d", lat, NIB); end
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL add_res: got %h expected %h", r, e.res); end
    n_checks++; if ({c, o} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL add_flags: got %b expected %b", {c, o}, {e.cout, e.ovf}); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL add_valid_drop: got %b expected 0", bus.out_valid); end
    n_checks++; if (bus.res !== e.res) begin n_fail++; $display("FAIL add_res_hold: got %h expected %h", bus.res, e.res); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL add_in_ready_after: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_sub();
    logic [W-1:0] av[3] = '{16'h1000, 16'h0000, 16'h8000};
    logic [W-1:0] bv[3] = '{16'h0001, 16'h0001, 16'h0001};
    int lat; logic [W-1:0] r; logic c, o; exp_t e;
    for (int i = 0; i < 3; i++) begin
      do_op(av[i], bv[i], 1'b1, 1'b0, 1'b0, lat, r, c, o);
      e = sb.pop_front();
      n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL sub_res[%0d]: got %h expected %h", i, r, e.res); end
      n_checks++; if ({c, o} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL sub_flags[%0d]: got %b expected %b", i, {c, o}, {e.cout, e.ovf}); end
      n_checks++; if (lat !== NIB) begin n_fail++; $display("FAIL sub_latency[%0d]: got %0d expected %0d", i, lat, NIB); end
    end
  endtask

  task automatic test_overflow();
    int lat; logic [W-1:0] r; logic c, o; exp_t e;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, r, c, o);
    e = sb.pop_front();
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL ovf_add_res: got %h expected %h", r, e.res); end
    n_checks++; if ({c, o} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL ovf_add_flags: got %b expected %b", {c, o}, {e.cout, e.ovf}); end
  endtask

  task automatic test_backpressure();
    int wait_n; exp_t e;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_start: got %b expected 1", bus.in_ready); end
    bus.op_a = 16'h1234; bus.op_b = 16'h0FFF; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb.push_back(model(16'h1234, 16'h0FFF, 1'b0));
    wait_n = 0;
    while (!bus.out_valid && wait_n < 50) begin @(posedge clk); #1; wait_n++; end
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got %b expected 1", bus.out_valid); end
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = (i != 1);
      bus.op_a = 16'hAAAA; bus.op_b = 16'h5555; bus.op_sub = 1'b1;
      @(posedge clk); #1;
      n_checks++; if (bus.res !== e.res) begin n_fail++; $display("FAIL bp_res[%0d]: got %h expected %h", i, bus.res, e.res); end
      n_checks++; if ({bus.cout, bus.ovf} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL bp_flags[%0d]: got %b expected %b", i, {bus.cout, bus.ovf}, {e.cout, e.ovf}); end
      n_checks++; if ({bus.in_ready, bus.out_valid} !== 2'b01) begin n_fail++; $display("FAIL bp_hs[%0d]: got %b expected 01", i, {bus.in_ready, bus.out_valid}); end
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_same_cycle_accept: got busy %b expected 0", bus.busy); end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_next: got %b expected 1", bus.in_ready); end
    n_checks++; if (bus.res !== e.res) begin n_fail++; $display("FAIL bp_res_after: got %h expected %h", bus.res, e.res); end
  endtask

  task automatic test_input_change();
    int lat; logic [W-1:0] r; logic c, o; exp_t e;
    do_op(16'h8765, 16'h4321, 1'b1, 1'b1, 1'b0, lat, r, c, o);
    e = sb.pop_front();
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL chg_res: got %h expected %h", r, e.res); end
    n_checks++; if ({c, o} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL chg_flags: got %b expected %b", {c, o}, {e.cout, e.ovf}); end
  endtask

  task automatic test_reset_abort();
    int seen; int lat; logic [W-1:0] r; logic c, o; exp_t e;
    bus.op_a = 16'h1111; bus.op_b = 16'h2222; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b100) begin n_fail++; $display("FAIL abort_hs: got %b expected 100", {bus.in_ready, bus.out_valid, bus.busy}); end
    n_checks++; if (bus.res !== 16'h0000) begin n_fail++; $display("FAIL abort_res: got %h expected 0000", bus.res); end
    n_checks++; if ({bus.cout, bus.ovf} !== 2'b00) begin n_fail++; $display("FAIL abort_flags: got %b expected 00", {bus.cout, bus.ovf}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d expected 0", seen); end
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat, r, c, o);
    e = sb.pop_front();
    n_checks++; if (r !== e.res) begin n_fail++; $display("FAIL abort_next_res: got %h expected %h", r, e.res); end
    n_checks++; if ({c, o} !== {e.cout, e.ovf}) begin n_fail++; $display("FAIL abort_next_flags: got %b expected %b", {c, o}, {e.cout, e.ovf}); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [W-1:0] r; logic c, o; exp_t e;
    for (int i = 0; i < 16; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'b1, lat, r, c, o);
      e = sb.pop_front();
      n_checks++; if ({r, c, o} !== {e.res, e.cout, e.ovf}) begin n_fail++; $display("FAIL b2b[%0d]: got %h/%b%b expected %h/%b%b", i, r, c, o, e.res, e.cout, e.ovf); end
      n_checks++; if (lat !== NIB) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, NIB); end
    end
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_backpressure();
    test_input_change();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/addsub_serial_ctrl.md
ADDSUB_SERIAL_CTRL -- requirements
Module: addsub_serial_ctrl

Interface
REQ-001 Parameter: NIB, default 4, number of 4-bit nibbles per operand; operand width W = 4*NIB; legal range 2..8.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operation request.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op_a  input  W  minuend or augend.
REQ-007 op_b  input  W  subtrahend or addend.
REQ-008 op_sub  input  1  0 = add, 1 = subtract (a - b).
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 res  output  W  result, modulo 2^W.
REQ-012 cout  output  1  carry out of the MSB nibble; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  signed two's-complement overflow.
REQ-014 busy  output  1  high in RUN or DONE.

Function
REQ-015 The block SHALL instantiate exactly one existing adder_sub_4bit slice and time-multiplex it LSB nibble first; no other adder SHALL be used for res.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE SHALL go to RUN on in_valid & in_ready; RUN SHALL go to DONE after NIB cycles; DONE SHALL go to IDLE on out_valid & out_ready.
REQ-018 in_ready SHALL be 1 only in IDLE; in_valid SHALL be ignored in RUN and DONE.
REQ-019 On accept, op_a, op_b and op_sub SHALL be registered; later input changes SHALL have no effect on the operation in flight.
REQ-020 On accept, the nibble counter SHALL clear to 0 and the carry register SHALL load op_sub.
REQ-021 In RUN cycle k (k = 0..NIB-1), the slice SHALL receive nibble k of a, nibble k of b, ctr = op_sub, and carry-in = the carry register.
REQ-022 Each RUN cycle SHALL store the slice sum into res nibble k and the slice carry-out into the carry register.
REQ-023 The first nibble SHALL use carry-in = op_sub, so a subtract computes a + ~b + 1.
REQ-024 Latency: out_valid SHALL rise exactly NIB clock edges after the accept edge; throughput SHALL be one operation per NIB+2 cycles minimum.
REQ-025 On entry to DONE, cout SHALL equal the final carry register.
REQ-026 On entry to DONE, ovf SHALL equal (a[W-1] == b_eff[W-1]) & (res[W-1] != a[W-1]), where b_eff = b ^ {W{op_sub}}.
REQ-027 res, cout and ovf SHALL be registered and SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-028 After DONE returns to IDLE, res, cout and ovf SHALL hold their last values; out_valid SHALL be 0.
REQ-029 out_ready asserted outside DONE SHALL have no effect.
REQ-030 A new request SHALL NOT be accepted in the same cycle as the result handshake; in_ready rises the cycle after.

Reset
REQ-031 rst_n low SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, carry 0, res 0, cout 0, ovf 0, out_valid 0, busy 0, in_ready 1.
REQ-032 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL be produced for it.
REQ-033 After rst_n rises, the first clock edge SHALL be able to accept a request.

Verification (NIB=4)
REQ-034 Add 0x1234 + 0x0FFF -> res 0x2233, cout 0, ovf 0; out_valid exactly 4 edges after accept.
REQ-035 Sub 0x1000 - 0x0001 -> res 0x0FFF, cout 1, ovf 0; sub 0x0000 - 0x0001 -> res 0xFFFF, cout 0, ovf 0.
REQ-036 Add 0x7FFF + 0x0001 -> res 0x8000, ovf 1; sub 0x8000 - 0x0001 -> res 0x7FFF, ovf 1, cout 1.
REQ-037 Backpressure: hold out_ready = 0 for 3 cycles in DONE.
- res, cout and ovf SHALL stay constant; in_ready SHALL stay 0.
- in_valid pulses in that window SHALL be ignored.
- After the handshake, in_ready SHALL be 1 on the next cycle.
REQ-038 Change op_a and op_b every cycle during RUN -> the result SHALL match the operands captured at accept.
REQ-039 Assert rst_n low after 2 RUN cycles.
- All outputs SHALL take their reset values asynchronously.
- No out_valid SHALL follow for the aborted operation.
- The next add 0xFFFF + 0x0001 SHALL give res 0x0000, cout 1, ovf 0.
